rriot_bus_master: RTL and testbench
===================================

// Module: rriot_bus_master
// PURPOSE
//  Bus initiator for the mcs6530-style RRIOT responder, clocked on phi2.
//  Takes single read/write commands over a valid/ready handshake and drives we_n/A/DI/RS0/CS1.
//  Samples DO/OE after a programmable wait and returns one response per command.
//  Lets testbenches and the future CPU-less loader reach RAM, ROM, I/O and timer registers.
// PARAMETERS
//  WAIT_CYCLES  1  cycles from address presentation to read sample; range 0..15; 0 = combinational responder
//  TXN_W        16 width of transaction counter
//  ERR_W        8  width of saturating error counter
// PORTS
//  clk        in   1   phi2 clock
//  rst_n      in   1   reset, synchronous, active-low
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   master accepts command this cycle
//  cmd_we     in   1   1 = write, 0 = read
//  cmd_rom    in   1   1 = ROM space (RS0=1, CS1=1); 0 = RAM/IO/timer (RS0=0, CS1=0)
//  cmd_addr   in   10  responder address
//  cmd_wdata  in   8   write data
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   consumer accepts response
//  rsp_rdata  out  8   read data; 8'h00 for writes and errored reads
//  rsp_err    out  1   read sampled with bus_oe=0
//  bus_we_n   out  1   to responder we_n
//  bus_a      out  10  to responder A
//  bus_di     out  8   to responder DI
//  bus_rs0    out  1   to responder RS0
//  bus_cs1    out  1   to responder chip-select line (PBI[6])
//  bus_do     in   8   from responder DO
//  bus_oe     in   1   from responder OE
//  clr_stats  in   1   clear both counters
//  txn_count  out  TXN_W  completed responses, wraps
//  err_count  out  ERR_W  errored responses, saturates at all-ones
// BEHAVIOUR
//  - Bus idle (reset and outside ADDR/HOLD): we_n=1, a=0, di=0, rs0=0, cs1=1.
//    This combination enables no responder region.
//  - Reset values: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counters=0, state IDLE.
//  - Reset mid-operation: abort to IDLE and return the bus to idle next edge. No response for the dropped command.
//  - FSM IDLE -> ADDR -> [HOLD] -> RESP -> IDLE. All outputs are registered.
//  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch the command and go to ADDR.
//  - ADDR (1 cycle): drive a/di/rs0/cs1 from the latched command; we_n=~cmd_we.
//    - Write: we_n is low for exactly this one cycle. Next state is RESP with rdata=0, err=0.
//    - Read, WAIT_CYCLES=0: sample bus_do/bus_oe at the edge ending ADDR, then go to RESP.
//    - Read, WAIT_CYCLES>0: go to HOLD with wait counter=WAIT_CYCLES.
//  - HOLD: hold address, we_n=1, decrement the counter. Sample at the edge where the counter reaches 0, then go to RESP.
//    Read address is therefore held 1+WAIT_CYCLES cycles.
//  - Sample rule: oe=1 gives rdata=bus_do, err=0. oe=0 gives rdata=8'h00, err=1.
//  - RESP: bus idle, rsp_valid=1, fields stable until rsp_ready. On the handshake go to IDLE.
//  - cmd_ready is 0 outside IDLE; no overlap.
//  - Latency, cmd accept to rsp_valid: write 2 cycles; read 2+WAIT_CYCLES cycles.
//  - Back-to-back minimum period: write 3 cycles; read 3+WAIT_CYCLES cycles.
//  - Counters: on each rsp handshake, txn_count+1 (wraps); err_count+1 if rsp_err (saturates).
//  - clr_stats coincident with an increment: clear wins.
// STRUCTURE
//  - rriot_pkg:
//    - state enum (IDLE, ADDR, HOLD, RESP)
//    - BUS_IDLE_* constants
//    - rriot_cmd_t struct {we, rom, addr[9:0], wdata[7:0]}
//    - rriot_rsp_t struct {rdata[7:0], err}
//  - Sub-module rriot_stats_ctr: txn and err counters with clear and saturation.
//  - FSM and bus drive stay in the top.
// TESTING
//  - Write then read RAM: wr addr 10'h0C5 data 8'hA5 -> we_n low 1 cycle;
//    then rd 10'h0C5 -> rdata=8'hA5, err=0, rsp_valid 3 cycles after accept.
//  - ROM read, cmd_rom=1, addr 10'h3FF: rs0=1, cs1=1 during access; rdata=ROM model byte, err=0.
//  - Unmapped read, addr 10'h100 with cmd_rom=0: responder OE=0 -> rdata=8'h00, err=1, err_count=1.
//  - Backpressure: rsp_ready=0 for 5 cycles -> rsp fields stable, cmd_ready=0, bus idle;
//    then handshake -> txn_count increments by exactly 1.
//  - Reset mid-read: rst_n=0 during HOLD (WAIT_CYCLES=3) -> next edge bus idle, no rsp_valid;
//    next command completes normally.
//  - Counters: 256 errored reads -> err_count=8'hFF (saturated);
//    clr_stats asserted on a handshake cycle -> both counters read 0.

Source files
------------

// File: rtl/rriot_pkg.sv
// Shared types and constants for the RRIOT bus initiator: FSM encoding,
// idle bus pattern, command/response records and the read-sample rule.
package rriot_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ADDR = ST_ADDR,
    HOLD = ST_HOLD,
    RESP = ST_RESP
  } rriot_state_e;

  // RS0=0 with CS1=1 selects no responder region.
  localparam logic       BUS_IDLE_WE_N = 1'b1;
  localparam logic [9:0] BUS_IDLE_A    = 10'h000;
  localparam logic [7:0] BUS_IDLE_DI   = 8'h00;
  localparam logic       BUS_IDLE_RS0  = 1'b0;
  localparam logic       BUS_IDLE_CS1  = 1'b1;

  typedef struct packed {
    logic       we_n;
    logic [9:0] a;
    logic [7:0] di;
    logic       rs0;
    logic       cs1;
  } rriot_bus_t;

  localparam rriot_bus_t BUS_IDLE = '{
    we_n: BUS_IDLE_WE_N,
    a:    BUS_IDLE_A,
    di:   BUS_IDLE_DI,
    rs0:  BUS_IDLE_RS0,
    cs1:  BUS_IDLE_CS1
  };

  typedef struct packed {
    logic       we;
    logic       rom;
    logic [9:0] addr;
    logic [7:0] wdata;
  } rriot_cmd_t;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } rriot_rsp_t;

  // A read with OE low returns zero data and flags an error.
  function automatic rriot_rsp_t sample_bus(input logic [7:0] data, input logic oe);
    rriot_rsp_t r;
    r.rdata = oe ? data : 8'h00;
    r.err   = ~oe;
    return r;
  endfunction

endpackage

// File: rtl/rriot_bus_master_stats.sv
// Transaction and error statistics: wrapping transaction count, saturating
// error count, synchronous clear that overrides any increment.
module rriot_stats_ctr
  import rriot_pkg::*;
#(
  parameter int TXN_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             inc_err,
  output logic [TXN_W-1:0] txn_count,
  output logic [ERR_W-1:0] err_count
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      txn_count <= '0;
      err_count <= '0;
    end else begin
      if (inc) txn_count <= txn_count + TXN_W'(1);
      if (inc && inc_err) err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: rtl/rriot_bus_master.sv
// Single-outstanding bus initiator for the RRIOT responder: accepts one
// command, runs the phi2 bus cycle with a programmable read wait, returns one response.
module rriot_bus_master
  import rriot_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int TXN_W       = 16,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic             cmd_rom,
  input  logic [9:0]       cmd_addr,
  input  logic [7:0]       cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_rdata,
  output logic             rsp_err,
  output logic             bus_we_n,
  output logic [9:0]       bus_a,
  output logic [7:0]       bus_di,
  output logic             bus_rs0,
  output logic             bus_cs1,
  input  logic [7:0]       bus_do,
  input  logic             bus_oe,
  input  logic             clr_stats,
  output logic [TXN_W-1:0] txn_count,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  rriot_state_e state;
  rriot_cmd_t   cmd_q;
  rriot_bus_t   bus_q;
  rriot_rsp_t   smp;
  logic [3:0]   wait_cnt;
  logic         rsp_hs;

  assign smp    = sample_bus(bus_do, bus_oe);
  assign rsp_hs = rsp_valid & rsp_ready;

  assign bus_we_n = bus_q.we_n;
  assign bus_a    = bus_q.a;
  assign bus_di   = bus_q.di;
  assign bus_rs0  = bus_q.rs0;
  assign bus_cs1  = bus_q.cs1;

  // Command and wait count are pure data; only their consumers are reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && cmd_valid && cmd_ready) begin
      cmd_q.we    <= cmd_we;
      cmd_q.rom   <= cmd_rom;
      cmd_q.addr  <= cmd_addr;
      cmd_q.wdata <= cmd_wdata;
    end
    if (state == ADDR) wait_cnt <= WAIT_INIT;
    else if (state == HOLD) wait_cnt <= wait_cnt - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
      bus_q     <= BUS_IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= ADDR;
            cmd_ready <= 1'b0;
            bus_q     <= '{we_n: ~cmd_we, a: cmd_addr, di: cmd_wdata,
                           rs0: cmd_rom, cs1: cmd_rom};
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ADDR: begin
          if (cmd_q.we) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
            bus_q     <= BUS_IDLE;
          end else if (WAIT_CYCLES == 0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= smp.rdata;
            rsp_err   <= smp.err;
            bus_q     <= BUS_IDLE;
          end else begin
            state <= HOLD;
            bus_q <= '{we_n: 1'b1, a: cmd_q.addr, di: cmd_q.wdata,
                       rs0: cmd_q.rom, cs1: cmd_q.rom};
          end
        end
        HOLD: begin
          // The edge on which the counter steps from 1 to 0 is the sample edge.
          if (wait_cnt == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= smp.rdata;
            rsp_err   <= smp.err;
            bus_q     <= BUS_IDLE;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
          bus_q     <= BUS_IDLE;
        end
      endcase
    end
  end

  rriot_stats_ctr #(
    .TXN_W(TXN_W),
    .ERR_W(ERR_W)
  ) u_stats (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_stats),
    .inc      (rsp_hs),
    .inc_err  (rsp_err),
    .txn_count(txn_count),
    .err_count(err_count)
  );

endmodule

// File: tb/tb_rriot_bus_master.sv
// Directed bench for rriot_bus_master with a small RAM/ROM responder model
// and a response scoreboard.
module tb_rriot_bus_master;

  localparam int WAIT = 3;
  localparam logic [20:0] IDLE_BUS = {1'b1, 10'h000, 8'h00, 1'b0, 1'b1};

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic        cmd_rom;
  logic [9:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        bus_we_n;
  logic [9:0]  bus_a;
  logic [7:0]  bus_di;
  logic        bus_rs0;
  logic        bus_cs1;
  logic [7:0]  bus_do;
  logic        bus_oe;
  logic        clr_stats;
  logic [15:0] txn_count;
  logic [7:0]  err_count;
  logic [20:0] bus_vec;

  rriot_bus_master #(
    .WAIT_CYCLES(WAIT),
    .TXN_W      (16),
    .ERR_W      (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_rom  (cmd_rom),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .bus_we_n (bus_we_n),
    .bus_a    (bus_a),
    .bus_di   (bus_di),
    .bus_rs0  (bus_rs0),
    .bus_cs1  (bus_cs1),
    .bus_do   (bus_do),
    .bus_oe   (bus_oe),
    .clr_stats(clr_stats),
    .txn_count(txn_count),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus_vec = {bus_we_n, bus_a, bus_di, bus_rs0, bus_cs1};

  // Responder model: RAM at 0x000-0x0FF (RS0=0, CS1=0), ROM anywhere with RS0=CS1=1.
  logic [7:0] ram [0:255];

  function automatic logic [7:0] rom_byte(input logic [9:0] a);
    return a[7:0] ^ {a[9:8], 6'h15};
  endfunction

  always_comb begin
    bus_do = 8'hEE;
    bus_oe = 1'b0;
    if (!bus_cs1 && !bus_rs0 && bus_a[9:8] == 2'b00) begin
      bus_do = ram[bus_a[7:0]];
      bus_oe = 1'b1;
    end else if (bus_cs1 && bus_rs0) begin
      bus_do = rom_byte(bus_a);
      bus_oe = 1'b1;
    end
  end

  always @(posedge clk)
    if (!bus_we_n && !bus_cs1 && !bus_rs0 && bus_a[9:8] == 2'b00)
      ram[bus_a[7:0]] <= bus_di;

  int we_low_total = 0;
  always @(negedge clk)
    if (bus_we_n === 1'b0) we_low_total++;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int exp_txn = 0;
  int exp_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_cmd(input logic we, input logic rom, input logic [9:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rdata,
                        input logic exp_e, input int stall, input logic clr);
    int   lat;
    int   we0;
    exp_t e;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_rom   = rom;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_e;
    sb.push_back(e);
    we0 = we_low_total;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("addr_phase_bus", 32'(bus_vec), 32'({~we, addr, wdata, rom, rom}));
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid !== 1'b1)
        check("hold_bus", 32'({bus_we_n, bus_a, bus_rs0, bus_cs1}),
              32'({1'b1, addr, rom, rom}));
    end
    check("latency", 32'(lat), we ? 32'd2 : 32'(2 + WAIT));
    check("we_n_low_cycles", 32'(we_low_total - we0), we ? 32'd1 : 32'd0);
    e = sb.pop_front();
    check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
    check("rsp_err", 32'(rsp_err), 32'(e.err));
    check("resp_bus_idle", 32'(bus_vec), 32'(IDLE_BUS));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_fields", 32'({rsp_rdata, rsp_err}), 32'({e.rdata, e.err}));
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      check("stall_bus_idle", 32'(bus_vec), 32'(IDLE_BUS));
      check("stall_txn", 32'(txn_count), 32'(exp_txn));
    end
    rsp_ready = 1'b1;
    clr_stats = clr;
    @(negedge clk);
    rsp_ready = 1'b0;
    clr_stats = 1'b0;
    if (clr) begin
      exp_txn = 0;
      exp_err = 0;
    end else begin
      exp_txn = (exp_txn + 1) & 16'hFFFF;
      if (e.err && exp_err < 255) exp_err++;
    end
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("txn_count", 32'(txn_count), 32'(exp_txn));
    check("err_count", 32'(err_count), 32'(exp_err));
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_rom   = 1'b0;
    cmd_addr  = 10'h000;
    cmd_wdata = 8'h00;
    rsp_ready = 1'b0;
    clr_stats = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_fields", 32'({rsp_rdata, rsp_err}), 32'd0);
    check("rst_counters", 32'({txn_count, err_count}), 32'd0);
    check("rst_bus_idle", 32'(bus_vec), 32'(IDLE_BUS));
    rst_n = 1'b1;

    // RAM write then read back; ROM read; unmapped read.
    do_cmd(1'b1, 1'b0, 10'h0C5, 8'hA5, 8'h00, 1'b0, 0, 1'b0);
    do_cmd(1'b0, 1'b0, 10'h0C5, 8'h00, 8'hA5, 1'b0, 0, 1'b0);
    do_cmd(1'b0, 1'b1, 10'h3FF, 8'h00, 8'h2A, 1'b0, 0, 1'b0);
    do_cmd(1'b0, 1'b0, 10'h100, 8'h00, 8'h00, 1'b1, 0, 1'b0);
    check("err_count_one", 32'(err_count), 32'd1);

    // Backpressure on a write and then a read.
    do_cmd(1'b1, 1'b0, 10'h012, 8'h3C, 8'h00, 1'b0, 5, 1'b0);
    do_cmd(1'b0, 1'b0, 10'h012, 8'h00, 8'h3C, 1'b0, 5, 1'b0);
    check("txn_after_bp", 32'(txn_count), 32'd6);

    // Reset while the read is in HOLD.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_rom   = 1'b0;
    cmd_addr  = 10'h0C5;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_hold", 32'({bus_we_n, bus_a, bus_cs1}), 32'({1'b1, 10'h0C5, 1'b0}));
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_bus_idle", 32'(bus_vec), 32'(IDLE_BUS));
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst_n   = 1'b1;
    exp_txn = 0;
    exp_err = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_cmd(1'b0, 1'b0, 10'h0C5, 8'h00, 8'hA5, 1'b0, 0, 1'b0);

    // Saturate the error counter.
    for (int i = 0; i < 256; i++)
      do_cmd(1'b0, 1'b0, 10'h100 | 10'(i), 8'h00, 8'h00, 1'b1, 0, 1'b0);
    check("err_saturated", 32'(err_count), 32'hFF);
    check("txn_after_sat", 32'(txn_count), 32'd257);

    // Clear coincident with an errored handshake, then normal counting resumes.
    do_cmd(1'b0, 1'b0, 10'h2AA, 8'h00, 8'h00, 1'b1, 0, 1'b1);
    check("clr_both_zero", 32'({txn_count, err_count}), 32'd0);
    do_cmd(1'b0, 1'b1, 10'h055, 8'h00, 8'h55 ^ 8'h15, 1'b0, 0, 1'b0);
    check("txn_after_clr", 32'(txn_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
